// File: rtl/exp4_unidade_controle_pkg.sv
// State codes, control-output bundle and the decode that maps each state
// to its Moore outputs for the play-round controller.
package exp4_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 5000;
  localparam int TMR_W_DEF          = 13;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE,
    FIM_TIMEOUT = 4'hF
  } estado_t;

  typedef struct packed {
    logic zeraC;
    logic zeraR;
    logic registraR;
    logic contaC;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } ctrl_t;

  function automatic ctrl_t decode_saidas(estado_t e);
    ctrl_t c;
    c           = '0;
    c.zeraC     = (e == PREPARACAO);
    c.zeraR     = (e == PREPARACAO);
    c.registraR = (e == REGISTRA);
    c.contaC    = (e == PROXIMO);
    c.pronto    = (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
    c.acertou   = (e == FIM_ACERTOU);
    c.errou     = (e == FIM_ERROU) || (e == FIM_TIMEOUT);
    c.timeout   = (e == FIM_TIMEOUT);
    return c;
  endfunction

endpackage

// File: rtl/exp4_unidade_controle_if.sv
// Handshake between the round controller and its datapath/test driver.
// The controller is the slave: it consumes status and produces controls.
interface exp4_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       fimC;
  logic       igual;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, fimC, igual,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout,
           db_estado
  );

  modport slave (
    input  iniciar, jogada, fimC, igual,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout,
           db_estado
  );
endinterface

// File: rtl/exp4_unidade_controle_edge_detector.sv
// Rising-edge detector: one-cycle pulse when sinal goes 0->1.
// A level held high produces exactly one pulse.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic r_sinal_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sinal_d <= 1'b0;
    else       r_sinal_d <= sinal;
  end

  assign pulso = sinal & ~r_sinal_d;

endmodule

// File: rtl/exp4_unidade_controle.sv
// Round sequencer: waits for plays, registers and compares them, and ends
// the round on full match, first mismatch or a no-play timeout.
module exp4_unidade_controle
  import exp4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TMR_W          = TMR_W_DEF
) (
  input logic                     clock,
  input logic                     reset,
  exp4_unidade_controle_if.slave  bus
);

  estado_t          r_estado;
  estado_t          w_prox;
  ctrl_t            r_ctrl;
  logic [TMR_W-1:0] r_tmr;
  logic             w_edge;
  logic             w_tmr_fim;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .sinal (bus.jogada),
    .pulso (w_edge)
  );

  assign w_tmr_fim = (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:    if (bus.iniciar) w_prox = PREPARACAO;
      PREPARACAO: w_prox = ESPERA;
      ESPERA: begin
        // a play arriving on the last wait cycle beats the timeout
        if (w_edge)         w_prox = REGISTRA;
        else if (w_tmr_fim) w_prox = FIM_TIMEOUT;
      end
      REGISTRA:   w_prox = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual)    w_prox = FIM_ERROU;
        else if (bus.fimC) w_prox = FIM_ACERTOU;
        else               w_prox = PROXIMO;
      end
      PROXIMO:    w_prox = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                  if (bus.iniciar) w_prox = PREPARACAO;
      default:    w_prox = INICIAL;
    endcase
  end

  // outputs are registered from the next state so they stay pure Moore
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_ctrl   <= '0;
      r_tmr    <= '0;
    end else begin
      r_estado <= w_prox;
      r_ctrl   <= decode_saidas(w_prox);
      if (r_estado != ESPERA)  r_tmr <= '0;
      else if (r_tmr != '1)    r_tmr <= r_tmr + 1'b1;
    end
  end

  assign bus.zeraC     = r_ctrl.zeraC;
  assign bus.zeraR     = r_ctrl.zeraR;
  assign bus.registraR = r_ctrl.registraR;
  assign bus.contaC    = r_ctrl.contaC;
  assign bus.pronto    = r_ctrl.pronto;
  assign bus.acertou   = r_ctrl.acertou;
  assign bus.errou     = r_ctrl.errou;
  assign bus.timeout   = r_ctrl.timeout;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for the round controller with an 8-cycle timeout.
module tb_exp4_unidade_controle;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n_conta;
  int   n_reg;
  int   base;

  exp4_unidade_controle_if bus ();

  exp4_unidade_controle #(.TIMEOUT_CYCLES(8), .TMR_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.contaC)    n_conta++;
    if (bus.registraR) n_reg++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // packed view of all 1-bit outputs: zeraC zeraR registraR contaC pronto acertou errou timeout
  function automatic logic [31:0] outs();
    return {24'd0, bus.zeraC, bus.zeraR, bus.registraR, bus.contaC,
            bus.pronto, bus.acertou, bus.errou, bus.timeout};
  endfunction

  // one press from espera; leaves the FSM in the state after comparacao
  task automatic play(input logic ig, input logic fc, input logic [3:0] exp_st);
    bus.jogada = 1'b1;
    tick();
    chk("registra_st", bus.db_estado, 4'h4);
    chk("registraR", bus.registraR, 1'b1);
    bus.jogada = 1'b0;
    tick();
    chk("comparacao_st", bus.db_estado, 4'h5);
    bus.igual = ig;
    bus.fimC  = fc;
    tick();
    chk("result_st", bus.db_estado, exp_st);
    if (exp_st == 4'h6) begin
      chk("contaC", bus.contaC, 1'b1);
      tick();
      chk("back_espera", bus.db_estado, 4'h2);
    end
  endtask

  task automatic start_round();
    bus.iniciar = 1'b1;
    tick();
    chk("prep_st", bus.db_estado, 4'h1);
    chk("prep_outs", outs(), 32'hC0);
    bus.iniciar = 1'b0;
    tick();
    chk("espera_st", bus.db_estado, 4'h2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; n_conta = 0; n_reg = 0;
    reset = 1'b1;
    bus.iniciar = 1'b0; bus.jogada = 1'b0; bus.fimC = 1'b0; bus.igual = 1'b1;
    #3;
    chk("rst_state", bus.db_estado, 4'h0);
    chk("rst_outs", outs(), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    tick();
    chk("idle_hold", bus.db_estado, 4'h0);

    // full match over 4 addresses
    start_round();
    base = n_conta;
    play(1'b1, 1'b0, 4'h6);
    play(1'b1, 1'b0, 4'h6);
    play(1'b1, 1'b0, 4'h6);
    play(1'b1, 1'b1, 4'hA);
    chk("match_conta", n_conta - base, 3);
    chk("acertou_outs", outs(), 32'h0C);
    tick();
    chk("acertou_hold", bus.db_estado, 4'hA);

    // mismatch at address 2
    bus.fimC = 1'b0;
    start_round();
    base = n_conta;
    play(1'b1, 1'b0, 4'h6);
    play(1'b1, 1'b0, 4'h6);
    play(1'b0, 1'b0, 4'hE);
    chk("errou_conta", n_conta - base, 2);
    chk("errou_outs", outs(), 32'h0A);

    // restart from fim_errou, iniciar ignored in espera, then timeout
    bus.igual = 1'b1;
    start_round();
    chk("flags_clear", outs(), 32'h00);
    bus.iniciar = 1'b1;
    tick();
    chk("iniciar_ignored", bus.db_estado, 4'h2);
    bus.iniciar = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("espera_wait", bus.db_estado, 4'h2);
    end
    tick();
    chk("timeout_st", bus.db_estado, 4'hF);
    chk("timeout_outs", outs(), 32'h0B);

    // play on the last wait cycle wins over the timeout
    start_round();
    for (int i = 0; i < 7; i++) tick();
    chk("last_wait", bus.db_estado, 4'h2);
    play(1'b1, 1'b0, 4'h6);

    // held jogada: one play only, next wait times out
    base = n_reg;
    bus.jogada = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) bus.igual = 1'b1;
    end
    chk("held_reg", n_reg - base, 1);
    chk("held_timeout_st", bus.db_estado, 4'hF);
    chk("held_timeout", bus.timeout, 1'b1);
    bus.jogada = 1'b0;
    tick();

    // asynchronous reset while in comparacao
    start_round();
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    tick();
    chk("pre_rst_cmp", bus.db_estado, 4'h5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_st", bus.db_estado, 4'h0);
    chk("async_rst_outs", outs(), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", bus.db_estado, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
